// File: rtl/outport_uart_tx.sv
// ---------------------------------------------------------------------------
// outport_uart_tx
//
// Byte-wide output port for a small processor core, backed by a transmit FIFO
// and an 8N1 / 8N2 UART serializer. The core writes bytes with a one-cycle
// strobe. It polls o_busy to learn when everything it wrote has left the pin.
//
// Parameters
//   G_CLOCK_DIVIDE  clock cycles per UART bit (2..65535)
//   G_FIFO_DEPTH    transmit FIFO entries (power of 2, 2..256)
//   G_NSTOP         stop bits per frame (1 or 2)
//
// Ports
//   i_clk       processor clock, all logic on the rising edge
//   i_rst       synchronous active-high reset
//   i_wr        one-cycle write strobe for i_data
//   i_data      byte written by the core
//   o_busy      FIFO non-empty or a frame in progress
//   o_full      FIFO holds G_FIFO_DEPTH entries
//   o_overflow  sticky, set when a write was dropped because the FIFO was full
//   o_uart_tx   serial line, idle high, driven from a flop
// ---------------------------------------------------------------------------
module outport_uart_tx #(
    parameter int G_CLOCK_DIVIDE = 868,
    parameter int G_FIFO_DEPTH   = 16,
    parameter int G_NSTOP        = 1
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_wr,
    input  logic [7:0] i_data,
    output logic       o_busy,
    output logic       o_full,
    output logic       o_overflow,
    output logic       o_uart_tx
);

    localparam int          AW         = $clog2(G_FIFO_DEPTH);
    localparam logic [AW:0] FULL_COUNT = (AW + 1)'(G_FIFO_DEPTH);
    localparam logic [15:0] BIT_RELOAD = 16'(G_CLOCK_DIVIDE - 1);
    localparam logic        STOP_LAST  = 1'(G_NSTOP - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP
    } state_t;

    state_t state_q, state_d;

    // FIFO storage and bookkeeping. The occupancy count is one bit wider than
    // the pointers, so "full" and "empty" stay distinct when the pointers meet.
    logic [7:0]    fifo_mem [G_FIFO_DEPTH];
    logic [AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [AW:0]   count_q;
    logic          overflow_q;

    // Serializer datapath.
    logic [15:0] baud_cnt_q;   // down-counter, cycles left in the current bit
    logic [2:0]  bit_cnt_q;    // data bit index, wraps 7 -> 0 on its own
    logic        stop_cnt_q;   // stop bit index
    logic [7:0]  shift_q;      // frame byte, LSB goes out first
    logic        tx_q;

    logic fifo_empty;
    logic fifo_full;
    logic push;
    logic pop;
    logic bit_done;
    logic line_d;

    assign fifo_empty = (count_q == '0);
    assign fifo_full  = (count_q == FULL_COUNT);
    // Full is taken from the occupancy before any pop in the same cycle. A
    // write that meets a full FIFO is dropped even if a slot frees up now.
    assign push       = i_wr && !fifo_full;
    assign bit_done   = (baud_cnt_q == '0);

    // -----------------------------------------------------------------------
    // FSM state register
    // -----------------------------------------------------------------------
    // NOTE: clocked state uses non-blocking assignments only. Then every flop
    // samples the values from before the edge, whatever the process order.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // -----------------------------------------------------------------------
    // FSM next state, pop request and the line value for the next cycle
    // -----------------------------------------------------------------------
    // NOTE: each output of this block gets a default before the case. No
    // path then leaves a signal unassigned, which would infer a latch.
    always_comb begin
        state_d = state_q;
        pop     = 1'b0;
        line_d  = 1'b1;
        case (state_q)
            S_IDLE: begin
                if (!fifo_empty) begin
                    state_d = S_START;
                    pop     = 1'b1;
                end
            end
            S_START: begin
                line_d = 1'b0;
                if (bit_done) begin
                    state_d = S_DATA;
                end
            end
            S_DATA: begin
                line_d = shift_q[0];
                if (bit_done && (bit_cnt_q == 3'd7)) begin
                    state_d = S_STOP;
                end
            end
            S_STOP: begin
                line_d = 1'b1;
                // The last cycle of the final stop bit chains straight into
                // the next frame. The line then shows no idle gap.
                if (bit_done && (stop_cnt_q == STOP_LAST)) begin
                    if (!fifo_empty) begin
                        state_d = S_START;
                        pop     = 1'b1;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // -----------------------------------------------------------------------
    // FIFO pointers, occupancy and overflow flag
    // -----------------------------------------------------------------------
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            case ({push, pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
            if (i_wr && fifo_full) begin
                overflow_q <= 1'b1;
            end
        end
    end

    // NOTE: the storage array has no reset. Reset empties the FIFO through the
    // pointers and count, so old contents are never read back, and the array
    // can map onto plain RAM.
    always_ff @(posedge i_clk) begin
        if (push && !i_rst) begin
            fifo_mem[wr_ptr_q] <= i_data;
        end
    end

    // -----------------------------------------------------------------------
    // Serializer datapath
    // -----------------------------------------------------------------------
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            baud_cnt_q <= '0;
            bit_cnt_q  <= '0;
            stop_cnt_q <= 1'b0;
            shift_q    <= '0;
            tx_q       <= 1'b1;
        end else begin
            // The pin follows the FSM by one cycle. A pop therefore shows
            // its start bit one edge after the pop edge.
            tx_q <= line_d;

            if (pop) begin
                shift_q    <= fifo_mem[rd_ptr_q];
                baud_cnt_q <= BIT_RELOAD;
            end else if (state_q != S_IDLE) begin
                if (!bit_done) begin
                    baud_cnt_q <= baud_cnt_q - 1'b1;
                end else if (state_d != S_IDLE) begin
                    baud_cnt_q <= BIT_RELOAD;
                end
                // When the FSM returns to idle the counter is already zero.
            end

            if (bit_done) begin
                case (state_q)
                    S_DATA: begin
                        shift_q   <= shift_q >> 1;
                        bit_cnt_q <= bit_cnt_q + 1'b1;
                    end
                    S_STOP: begin
                        stop_cnt_q <= (stop_cnt_q == STOP_LAST) ? 1'b0
                                                                : stop_cnt_q + 1'b1;
                    end
                    default: begin
                        bit_cnt_q <= bit_cnt_q;
                    end
                endcase
            end
        end
    end

    assign o_busy     = !fifo_empty || (state_q != S_IDLE);
    assign o_full     = fifo_full;
    assign o_overflow = overflow_q;
    assign o_uart_tx  = tx_q;

endmodule

// File: tb/tb_outport_uart_tx.sv
// ---------------------------------------------------------------------------
// tb_outport_uart_tx
//
// Bench for outport_uart_tx. Instance dut runs with divide 4, depth 4 and one
// stop bit. Instance dut2 runs with two stop bits.
//
// Bytes the FIFO should accept go into exp_q when they are written. A line
// monitor spots each start bit and pops the expected byte. It then compares
// every cycle of the 40-cycle frame against the ideal waveform and records
// the cycle of the start bit.
//
// The monitor samples 1 ns after the rising edge. The tests sample 2 ns after
// it, so the tests see the monitor's update for the same cycle. Inputs change
// on the falling edge.
// ---------------------------------------------------------------------------
module tb_outport_uart_tx;

    localparam int DIV    = 4;
    localparam int DEPTH  = 4;
    localparam int FRAME1 = DIV * 10;
    localparam int FRAME2 = DIV * 11;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       wr  = 1'b0;
    logic [7:0] data = 8'h00;
    logic       busy, full, overflow, tx;

    logic       rst2  = 1'b1;
    logic       wr2   = 1'b0;
    logic [7:0] data2 = 8'h00;
    logic       busy2, full2, overflow2, tx2;

    always #5 clk = ~clk;

    outport_uart_tx #(
        .G_CLOCK_DIVIDE(DIV),
        .G_FIFO_DEPTH  (DEPTH),
        .G_NSTOP       (1)
    ) dut (
        .i_clk     (clk),
        .i_rst     (rst),
        .i_wr      (wr),
        .i_data    (data),
        .o_busy    (busy),
        .o_full    (full),
        .o_overflow(overflow),
        .o_uart_tx (tx)
    );

    outport_uart_tx #(
        .G_CLOCK_DIVIDE(DIV),
        .G_FIFO_DEPTH  (DEPTH),
        .G_NSTOP       (2)
    ) dut2 (
        .i_clk     (clk),
        .i_rst     (rst2),
        .i_wr      (wr2),
        .i_data    (data2),
        .o_busy    (busy2),
        .o_full    (full2),
        .o_overflow(overflow2),
        .o_uart_tx (tx2)
    );

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    logic [7:0] exp_q[$];
    logic [7:0] exp2_q[$];
    int         start_q[$];
    int         frames_seen = 0;

    // Ideal line value at sample idx of a frame carrying byte b.
    function automatic logic line_bit(input int idx, input logic [7:0] b);
        int k;
        k = idx / DIV;
        if (k == 0) return 1'b0;
        if (k <= 8) return b[k-1];
        return 1'b1;
    endfunction

    // ---------------------------------------------------------------------
    // Line monitor / scoreboard for dut
    // ---------------------------------------------------------------------
    bit         mon_active = 1'b0;
    bit         mon_unexp  = 1'b0;
    int         mon_idx    = 0;
    int         mon_bad    = 0;
    logic [7:0] mon_exp    = 8'h00;
    logic [7:0] mon_obs    = 8'h00;

    always @(posedge clk) begin
        #1;
        if (rst) begin
            mon_active = 1'b0;
        end else begin
            if (!mon_active && (tx === 1'b0)) begin
                mon_active = 1'b1;
                mon_idx    = 0;
                mon_bad    = 0;
                mon_obs    = 8'h00;
                start_q.push_back(cyc);
                if (exp_q.size() == 0) begin
                    mon_unexp = 1'b1;
                    mon_exp   = 8'h00;
                end else begin
                    mon_unexp = 1'b0;
                    mon_exp   = exp_q.pop_front();
                end
            end
            if (mon_active) begin
                if (tx !== line_bit(mon_idx, mon_exp)) mon_bad++;
                if ((mon_idx % DIV == 0) && (mon_idx / DIV >= 1) && (mon_idx / DIV <= 8))
                    mon_obs[mon_idx/DIV-1] = tx;
                if (mon_idx == FRAME1 - 1) begin
                    checks++;
                    frames_seen++;
                    if (mon_unexp || (mon_bad != 0)) begin
                        errors++;
                        $display("FAIL frame_%0d: line gave byte %02h with %0d bad samples (unexpected=%0d), required %02h",
                                 frames_seen, mon_obs, mon_bad, mon_unexp, mon_exp);
                    end
                    mon_active = 1'b0;
                end else begin
                    mon_idx++;
                end
            end
        end
    end

    // ---------------------------------------------------------------------
    // Stimulus helpers (no comparisons inside)
    // ---------------------------------------------------------------------
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic drive_write(input logic [7:0] b, input bit accept);
        @(negedge clk);
        wr   = 1'b1;
        data = b;
        if (accept) exp_q.push_back(b);
    endtask

    task automatic drive_idle();
        @(negedge clk);
        wr   = 1'b0;
        data = 8'($urandom);
    endtask

    task automatic apply_reset();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic wait_frames(input int target, input int budget, output bit ok);
        for (int i = 0; i < budget && frames_seen < target; i++) tick();
        ok = (frames_seen >= target);
    endtask

    // ---------------------------------------------------------------------
    // Tests
    // ---------------------------------------------------------------------
    task automatic test_reset();
        repeat (2) @(negedge clk);
        checks++;
        if ({tx, busy, full, overflow} !== 4'b1000) begin
            errors++;
            $display("FAIL reset_state: tx/busy/full/ovf=%b, required 1000",
                     {tx, busy, full, overflow});
        end
        checks++;
        if ({tx2, busy2, full2, overflow2} !== 4'b1000) begin
            errors++;
            $display("FAIL reset_state2: tx/busy/full/ovf=%b, required 1000",
                     {tx2, busy2, full2, overflow2});
        end
        rst  = 1'b0;
        rst2 = 1'b0;
        tick();
        checks++;
        if ({tx, busy} !== 2'b10) begin
            errors++;
            $display("FAIL idle_after_reset: tx/busy=%b, required 10", {tx, busy});
        end
    endtask

    task automatic test_single();
        int c, s, sb, fb;
        bit ok;
        sb = start_q.size();
        fb = frames_seen;
        @(negedge clk);
        c = cyc;
        wr = 1'b1;
        data = 8'hA5;
        exp_q.push_back(8'hA5);
        drive_idle();
        s = c + 3;   // write edge c+1, pop edge c+2, start bit after edge c+3
        for (int i = 0; i < 100 && frames_seen < fb + 1; i++) begin
            tick();
            if (cyc == s + FRAME1 - 2) begin
                checks++;
                if (busy !== 1'b1) begin
                    errors++;
                    $display("FAIL single_busy_in_stop: busy=%b, required 1", busy);
                end
            end
        end
        checks++;
        if (frames_seen < fb + 1) begin
            errors++;
            $display("FAIL single_timeout: frames=%0d, required %0d", frames_seen - fb, 1);
        end
        checks++;
        if (start_q.size() <= sb || start_q[sb] != s) begin
            errors++;
            $display("FAIL single_start_cycle: start at %0d, required %0d",
                     (start_q.size() > sb) ? start_q[sb] : -1, s);
        end
        while (cyc < s + FRAME1) tick();
        checks++;
        if ({busy, tx} !== 2'b01) begin
            errors++;
            $display("FAIL single_idle_after: busy/tx=%b, required 01", {busy, tx});
        end
        ok = 1'b1;
    endtask

    task automatic test_back_to_back();
        int c, sb, fb;
        bit ok;
        sb = start_q.size();
        fb = frames_seen;
        @(negedge clk);
        c = cyc;
        wr = 1'b1;
        data = 8'h00;
        exp_q.push_back(8'h00);
        drive_write(8'hFF, 1'b1);
        drive_write(8'h55, 1'b1);
        drive_idle();
        wait_frames(fb + 3, 250, ok);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL b2b_timeout: frames=%0d, required 3", frames_seen - fb);
        end
        for (int k = 0; k < 3; k++) begin
            checks++;
            if (start_q.size() <= sb + k || start_q[sb+k] != c + 3 + k * FRAME1) begin
                errors++;
                $display("FAIL b2b_start_%0d: start at %0d, required %0d", k,
                         (start_q.size() > sb + k) ? start_q[sb+k] : -1, c + 3 + k * FRAME1);
            end
        end
        tick();
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL b2b_busy_end: busy=%b, required 0", busy);
        end
    endtask

    task automatic test_overflow();
        int fb;
        bit ok;
        fb = frames_seen;
        for (int k = 0; k < 5; k++) drive_write(8'(8'h11 + k), 1'b1);
        tick();
        checks++;
        if ({full, overflow} !== 2'b10) begin
            errors++;
            $display("FAIL ovf_fill: full/ovf=%b, required 10", {full, overflow});
        end
        drive_write(8'h16, 1'b0);
        drive_idle();
        checks++;
        if ({full, overflow} !== 2'b11) begin
            errors++;
            $display("FAIL ovf_drop: full/ovf=%b, required 11", {full, overflow});
        end
        wait_frames(fb + 5, 300, ok);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL ovf_timeout: frames=%0d, required 5", frames_seen - fb);
        end
        repeat (60) tick();
        checks++;
        if (frames_seen != fb + 5 || exp_q.size() != 0) begin
            errors++;
            $display("FAIL ovf_frame_count: frames=%0d pending=%0d, required 5 and 0",
                     frames_seen - fb, exp_q.size());
        end
        checks++;
        if ({overflow, full, busy} !== 3'b100) begin
            errors++;
            $display("FAIL ovf_sticky: ovf/full/busy=%b, required 100", {overflow, full, busy});
        end
    endtask

    task automatic test_full_pop();
        int c, s, sb, fb;
        bit ok;
        apply_reset();
        checks++;
        if (overflow !== 1'b0) begin
            errors++;
            $display("FAIL fp_reset_ovf: ovf=%b, required 0", overflow);
        end
        sb = start_q.size();
        fb = frames_seen;
        @(negedge clk);
        c = cyc;
        wr = 1'b1;
        data = 8'h21;
        exp_q.push_back(8'h21);
        for (int k = 1; k < 5; k++) drive_write(8'(8'h21 + k), 1'b1);
        drive_idle();
        s = c + 3;
        while (cyc < s + FRAME1 - 2) tick();
        checks++;
        if ({full, overflow} !== 2'b10) begin
            errors++;
            $display("FAIL fp_before: full/ovf=%b, required 10", {full, overflow});
        end
        // This write lands on the edge that pops the next byte.
        drive_write(8'hEE, 1'b0);
        drive_idle();
        checks++;
        if ({full, overflow} !== 2'b01) begin
            errors++;
            $display("FAIL fp_after: full/ovf=%b, required 01", {full, overflow});
        end
        wait_frames(fb + 5, 300, ok);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL fp_timeout: frames=%0d, required 5", frames_seen - fb);
        end
        checks++;
        if (start_q.size() <= sb + 1 || start_q[sb+1] != s + FRAME1) begin
            errors++;
            $display("FAIL fp_contiguous: second start at %0d, required %0d",
                     (start_q.size() > sb + 1) ? start_q[sb+1] : -1, s + FRAME1);
        end
        repeat (60) tick();
        checks++;
        if (frames_seen != fb + 5 || exp_q.size() != 0) begin
            errors++;
            $display("FAIL fp_frame_count: frames=%0d pending=%0d, required 5 and 0",
                     frames_seen - fb, exp_q.size());
        end
    endtask

    task automatic test_reset_mid();
        int c, s, sb, fb, bad;
        apply_reset();
        @(negedge clk);
        c = cyc;
        wr = 1'b1;
        data = 8'h3C;
        exp_q.push_back(8'h3C);
        drive_write(8'h01, 1'b1);
        drive_write(8'h02, 1'b1);
        drive_idle();
        s = c + 3;
        while (cyc < s + 14) tick();
        checks++;
        if ({busy, tx} !== {1'b1, line_bit(14, 8'h3C)}) begin
            errors++;
            $display("FAIL rm_mid_data: busy/tx=%b, required %b",
                     {busy, tx}, {1'b1, line_bit(14, 8'h3C)});
        end
        // Reset with a write on the same edge: the write must be ignored.
        @(negedge clk);
        rst = 1'b1;
        wr = 1'b1;
        data = 8'h77;
        @(negedge clk);
        rst = 1'b0;
        wr = 1'b0;
        checks++;
        if ({tx, busy, full, overflow} !== 4'b1000) begin
            errors++;
            $display("FAIL rm_after_reset: tx/busy/full/ovf=%b, required 1000",
                     {tx, busy, full, overflow});
        end
        exp_q.delete();
        sb = start_q.size();
        fb = frames_seen;
        bad = 0;
        for (int i = 0; i < 120; i++) begin
            tick();
            data = 8'($urandom);
            if (tx !== 1'b1) bad++;
        end
        checks++;
        if (bad != 0 || frames_seen != fb || start_q.size() != sb || busy !== 1'b0) begin
            errors++;
            $display("FAIL rm_quiet: low samples=%0d frames=%0d starts=%0d busy=%b, required 0/0/0/0",
                     bad, frames_seen - fb, start_q.size() - sb, busy);
        end
    endtask

    task automatic test_two_stop();
        int c, s, bad, high_stop;
        logic [7:0] e;
        @(negedge clk);
        c = cyc;
        wr2 = 1'b1;
        data2 = 8'h81;
        exp2_q.push_back(8'h81);
        @(negedge clk);
        wr2 = 1'b0;
        for (int i = 0; i < 20 && tx2 !== 1'b0; i++) tick();
        s = cyc;
        checks++;
        if (tx2 !== 1'b0 || s != c + 3) begin
            errors++;
            $display("FAIL ns2_start: start at %0d tx=%b, required %0d and 0", s, tx2, c + 3);
        end
        e = exp2_q.pop_front();
        bad = 0;
        high_stop = 0;
        for (int idx = 0; idx < FRAME2; idx++) begin
            if (tx2 !== line_bit(idx, e)) bad++;
            if (idx >= 9 * DIV && tx2 === 1'b1) high_stop++;
            if (idx == FRAME2 - 2) begin
                checks++;
                if (busy2 !== 1'b1) begin
                    errors++;
                    $display("FAIL ns2_busy_in_stop: busy=%b, required 1", busy2);
                end
            end
            tick();
        end
        checks++;
        if (bad != 0 || high_stop != 2 * DIV) begin
            errors++;
            $display("FAIL ns2_frame: %0d bad samples, stop high %0d cycles, required 0 and %0d",
                     bad, high_stop, 2 * DIV);
        end
        checks++;
        if ({busy2, tx2} !== 2'b01) begin
            errors++;
            $display("FAIL ns2_idle_after: busy/tx=%b at %0d cycles, required 01",
                     {busy2, tx2}, cyc - s);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_overflow();
        test_full_pop();
        test_reset_mid();
        test_two_stop();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/outport_uart_tx.md
OUTPORT_UART_TX -- requirements
Module: outport_uart_tx

Interface
REQ-001 SHALL provide parameter G_CLOCK_DIVIDE, default 868, clock cycles per UART bit (legal 2..65535).
REQ-002 SHALL provide parameter G_FIFO_DEPTH, default 16, transmit FIFO entries (power of 2, 2..256).
REQ-003 SHALL provide parameter G_NSTOP, default 1, stop bits per frame (1 or 2).
REQ-004 SHALL provide port i_clk  input  1  processor clock; all logic rises on posedge.
REQ-005 SHALL provide port i_rst  input  1  reset; one clock; reset is synchronous and active-high.
REQ-006 SHALL provide port i_wr  input  1  core output-port strobe; one-cycle write of i_data.
REQ-007 SHALL provide port i_data  input  8  byte written by the core.
REQ-008 SHALL provide port o_busy  output  1  FIFO non-empty or frame in progress (core input-port status).
REQ-009 SHALL provide port o_full  output  1  FIFO holds G_FIFO_DEPTH entries.
REQ-010 SHALL provide port o_overflow  output  1  sticky: a write was dropped.
REQ-011 SHALL provide port o_uart_tx  output  1  serial line, idle high, registered.

Function
REQ-012 SHALL push i_data into the FIFO on any posedge with i_wr=1 and o_full=0.
REQ-013 SHALL evaluate full against the occupancy before any same-cycle pop: i_wr while o_full=1 drops the byte and sets o_overflow even if a pop occurs that cycle.
REQ-014 SHALL hold o_overflow at 1 until i_rst; further drops change nothing.
REQ-015 SHALL implement states IDLE, START, DATA, STOP; IDLE->START when FIFO non-empty, popping the head into a shift register in that same cycle.
REQ-016 SHALL drive o_uart_tx low starting the cycle after the pop (a write into an empty idle block shows the start bit two edges after the write edge).
REQ-017 SHALL hold every bit for exactly G_CLOCK_DIVIDE cycles, counted by a down-counter reloaded at each bit boundary.
REQ-018 SHALL send 8 data bits LSB first in DATA, tracked by a 3-bit counter, then G_NSTOP stop bits high in STOP.
REQ-019 SHALL, at the last cycle of the final stop bit, go directly to START with a pop if the FIFO is non-empty (no idle gap), else to IDLE.
REQ-020 SHALL assert o_busy whenever occupancy >0 or state != IDLE, combinationally from registered state.
REQ-021 SHALL wrap FIFO read/write pointers modulo G_FIFO_DEPTH with an extra occupancy bit distinguishing full from empty.
REQ-022 SHALL ignore i_data when i_wr=0.

Reset
REQ-023 SHALL, on i_rst=1 at a posedge, set state IDLE, FIFO empty, counters zero, o_uart_tx=1, o_busy=0, o_full=0, o_overflow=0.
REQ-024 SHALL abort any frame mid-transmission on reset: o_uart_tx returns high the cycle after the reset edge and queued bytes are discarded.
REQ-025 SHALL ignore i_wr on a cycle where i_rst=1.

Verification (G_CLOCK_DIVIDE=4, G_FIFO_DEPTH=4, G_NSTOP=1 unless stated)
REQ-026 SHALL verify: single write 0xA5 into idle block -> o_uart_tx low 2 edges later for 4 cycles, then 1,0,1,0,0,1,0,1 each 4 cycles, stop high 4 cycles; o_busy falls after the stop bit; 40 cycles start-to-idle.
REQ-027 SHALL verify: 3 back-to-back writes 0x00,0xFF,0x55 -> three contiguous 40-cycle frames with no idle cycles between stop and next start.
REQ-028 SHALL verify: 6 consecutive writes while idle -> first popped, next 4 fill FIFO (o_full=1), sixth dropped, o_overflow=1 and stays 1; exactly 5 frames sent.
REQ-029 SHALL verify: write while o_full=1 in the same cycle as a frame-boundary pop -> byte dropped, o_overflow=1, occupancy drops by 1.
REQ-030 SHALL verify: i_rst asserted mid-DATA of 0x3C with 2 bytes queued -> o_uart_tx=1, o_busy=0, o_full=0, o_overflow=0 next cycle; no further frames.
REQ-031 SHALL verify: G_NSTOP=2, write 0x81 -> stop period high for 8 cycles; frame 44 cycles.
